// File: rtl/intr_timer_ctrl.sv
// Machine timer plus N_EXT external interrupt channels.
// Drives the 2-bit intr code and the winning channel id to CSR/FSU.
module intr_timer_ctrl #(
  parameter int N_EXT    = 4,
  parameter int TIMER_W  = 32,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_EXT-1:0] ext_in,
  input  logic [2:0]       addr,
  input  logic [31:0]      wdata,
  input  logic             wr,
  input  logic             rd,
  output logic [31:0]      rdata,
  output logic [1:0]       intr,
  output logic [3:0]       ext_id,
  output logic             timer_intr
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]      presc;
  logic [TIMER_W-1:0] mtime;
  logic [TIMER_W-1:0] mtimecmp;
  logic [N_EXT:0]     enable;
  logic [N_EXT-1:0]   mode;
  logic [N_EXT-1:0]   edge_pend;
  logic [N_EXT-1:0]   s1, s2, s3;

  logic               tick;
  logic               wr_mtime, wr_cmp, wr_en;
  logic               wr_mode, wr_claim;
  logic [N_EXT-1:0]   clr;
  logic [N_EXT-1:0]   mode_chg;
  logic [N_EXT-1:0]   rise;
  logic [N_EXT-1:0]   pending;
  logic [N_EXT-1:0]   act;
  logic               ext_any;
  logic               unused;

  assign unused   = ^{wdata, rd};
  assign tick     = (presc == P_LAST);
  assign wr_mtime = wr && (addr == 3'd0);
  assign wr_cmp   = wr && (addr == 3'd1);
  assign wr_en    = wr && (addr == 3'd2);
  assign wr_mode  = wr && (addr == 3'd3);
  assign wr_claim = wr && (addr == 3'd5);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      enable   <= '0;
      mode     <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (wr_mtime)
        mtime <= wdata[TIMER_W-1:0];
      else if (tick)
        mtime <= mtime + 1'b1;
      if (wr_cmp)
        mtimecmp <= wdata[TIMER_W-1:0];
      if (wr_en)
        enable <= wdata[N_EXT:0];
      if (wr_mode)
        mode <= wdata[N_EXT-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= ext_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_EXT; i++)
      clr[i] = wr_claim && (wdata[3:0] == 4'(i));
  end

  assign mode_chg = wr_mode ? (wdata[N_EXT-1:0] ^ mode) : '0;
  assign rise     = s2 & ~s3;

  // A mode flip in either direction discards the stored edge; set beats claim.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      edge_pend <= '0;
    else
      edge_pend <= mode & ~mode_chg
                 & (rise | (edge_pend & ~clr));
  end

  assign pending = (mode & edge_pend) | (~mode & s2);
  assign act     = pending & enable[N_EXT-1:0];
  assign ext_any = |act;

  always_comb begin
    ext_id = 4'd0;
    for (int i = N_EXT - 1; i >= 0; i--)
      if (act[i])
        ext_id = 4'(i);
  end

  assign timer_intr = (mtime >= mtimecmp);

  always_comb begin
    intr = 2'b00;
    if (timer_intr && enable[N_EXT])
      intr = 2'b11;
    else if (ext_any)
      intr = 2'b10;
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      3'd0: rdata = 32'(mtime);
      3'd1: rdata = 32'(mtimecmp);
      3'd2: rdata = 32'(enable);
      3'd3: rdata = 32'(mode);
      3'd4: rdata = 32'(pending);
      3'd5: rdata = ext_any ? 32'(ext_id) + 32'd1 : 32'd0;
      default: rdata = 32'd0;
    endcase
  end

endmodule
